// File: rtl/ascon_permutation_pkg.sv
// Shared types, encodings and helpers for the Ascon-p permutation engine.
// Holds the FSM state encoding, rounds_sel encoding, the state struct and the round-constant function.
package ascon_permutation_pkg;

  typedef logic [63:0] word_t;

  // x0 sits in the MSBs so {S_0,S_1,S_2,S_3,S_4} packs directly into this struct.
  typedef struct packed {
    word_t x0;
    word_t x1;
    word_t x2;
    word_t x3;
    word_t x4;
  } ascon_state_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SEL_P12     = 2'b00,
    SEL_P8      = 2'b01,
    SEL_P6      = 2'b10,
    SEL_P12_ALT = 2'b11
  } rounds_sel_e;

  function automatic logic [7:0] round_const(input logic [3:0] i);
    return {4'hF - i, i};
  endfunction

  // The counter starts at 12-nr so every variant finishes on the same final round index.
  function automatic logic [3:0] start_ctr(input logic [1:0] sel);
    logic [3:0] ctr;
    case (rounds_sel_e'(sel))
      SEL_P8:  ctr = 4'd4;
      SEL_P6:  ctr = 4'd6;
      default: ctr = 4'd0;
    endcase
    return ctr;
  endfunction

  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (64 - n));
  endfunction

endpackage

// File: rtl/ascon_permutation_if.sv
// Request/result bundle between the core controller (master) and the permutation engine (slave).
interface ascon_permutation_if;
  logic        start;
  logic [1:0]  rounds_sel;
  logic [63:0] S_in_0, S_in_1, S_in_2, S_in_3, S_in_4;
  logic [63:0] S_0_reg, S_1_reg, S_2_reg, S_3_reg, S_4_reg;
  logic        busy;
  logic        done;

  modport master (
    output start, rounds_sel, S_in_0, S_in_1, S_in_2, S_in_3, S_in_4,
    input  S_0_reg, S_1_reg, S_2_reg, S_3_reg, S_4_reg, busy, done
  );

  modport slave (
    input  start, rounds_sel, S_in_0, S_in_1, S_in_2, S_in_3, S_in_4,
    output S_0_reg, S_1_reg, S_2_reg, S_3_reg, S_4_reg, busy, done
  );
endinterface

// File: rtl/ascon_round.sv
// One combinational Ascon round: constant addition, bitsliced 5-bit S-box layer, linear diffusion.
module ascon_round
  import ascon_permutation_pkg::*;
(
  input  ascon_state_t s_i,
  input  logic [7:0]   rc_i,
  output ascon_state_t s_o
);

  word_t x0, x1, x2, x3, x4;
  word_t t0, t1, t2, t3, t4;

  always_comb begin
    // NOTE: blocking assignments here model the in-place update sequence; each line sees the previous line's result.
    x0 = s_i.x0;
    x1 = s_i.x1;
    x2 = s_i.x2 ^ {56'd0, rc_i};
    x3 = s_i.x3;
    x4 = s_i.x4;

    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;

    s_o.x0 = x0 ^ rotr(x0, 19) ^ rotr(x0, 28);
    s_o.x1 = x1 ^ rotr(x1, 61) ^ rotr(x1, 39);
    s_o.x2 = x2 ^ rotr(x2, 1)  ^ rotr(x2, 6);
    s_o.x3 = x3 ^ rotr(x3, 10) ^ rotr(x3, 17);
    s_o.x4 = x4 ^ rotr(x4, 7)  ^ rotr(x4, 41);
  end

endmodule

// File: rtl/ascon_permutation.sv
// Iterative Ascon-p12/p8/p6 engine: FSM, round counter and 320-bit state register.
// Define ASCON_UNROLL2_EN to run two chained rounds per RUN cycle.
module ascon_permutation
  import ascon_permutation_pkg::*;
(
  input logic               clk,
  input logic               rst_n,
  ascon_permutation_if.slave bus
);

`ifdef ASCON_UNROLL2_EN
  localparam logic [3:0] CTR_STEP = 4'd2;
  localparam logic [3:0] LAST_CTR = 4'd10;
`else
  localparam logic [3:0] CTR_STEP = 4'd1;
  localparam logic [3:0] LAST_CTR = 4'd11;
`endif

  state_e       state_q, state_d;
  logic [3:0]   ctr_q, ctr_d;
  ascon_state_t s_q, s_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;

  ascon_state_t s_r0, s_step;
  logic [7:0]   rc0;

  assign rc0 = round_const(ctr_q);

  ascon_round u_round0 (.s_i(s_q), .rc_i(rc0), .s_o(s_r0));

`ifdef ASCON_UNROLL2_EN
  logic [7:0]   rc1;
  ascon_state_t s_r1;

  assign rc1 = round_const(ctr_q + 4'd1);

  ascon_round u_round1 (.s_i(s_r0), .rc_i(rc1), .s_o(s_r1));

  assign s_step = s_r1;
`else
  assign s_step = s_r0;
`endif

  always_comb begin
    // NOTE: every *_d gets a default first so no path through the case can infer a latch.
    state_d = state_q;
    ctr_d   = ctr_q;
    s_d     = s_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          s_d     = {bus.S_in_0, bus.S_in_1, bus.S_in_2, bus.S_in_3, bus.S_in_4};
          ctr_d   = start_ctr(bus.rounds_sel);
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        // start is deliberately not looked at here; a request mid-run is dropped.
        s_d = s_step;
        if (ctr_q == LAST_CTR) begin
          state_d = ST_DONE;
        end else begin
          ctr_d = ctr_q + CTR_STEP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ctr_q   <= '0;
      s_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
      s_q     <= s_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.S_0_reg = s_q.x0;
  assign bus.S_1_reg = s_q.x1;
  assign bus.S_2_reg = s_q.x2;
  assign bus.S_3_reg = s_q.x3;
  assign bus.S_4_reg = s_q.x4;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_ascon_permutation.sv
// Directed bench for ascon_permutation: KAT, p8/p6 against a table-driven S-box model,
// start-during-run, back-to-back, mid-run reset and idle hold.
module tb_ascon_permutation;
  import ascon_permutation_pkg::*;

`ifdef ASCON_UNROLL2_EN
  localparam int UNROLL = 2;
`else
  localparam int UNROLL = 1;
`endif

  // Ascon 5-bit S-box, entry v at bits [5v +: 5]; input/output bit 4 is the x0 slice.
  localparam logic [159:0] SBOX_TBL = {
    5'h17, 5'h0f, 5'h0a, 5'h16, 5'h19, 5'h01, 5'h0c, 5'h10,
    5'h18, 5'h11, 5'h0d, 5'h00, 5'h0e, 5'h07, 5'h13, 5'h1e,
    5'h1c, 5'h06, 5'h03, 5'h1d, 5'h12, 5'h08, 5'h05, 5'h1b,
    5'h02, 5'h09, 5'h15, 5'h1a, 5'h14, 5'h1f, 5'h0b, 5'h04
  };

  localparam ascon_state_t KAT_IN  = {64'h00400c0000000100, 64'h0, 64'h0, 64'h0, 64'h0};
  localparam ascon_state_t KAT_OUT = {64'hee9398aadb67f03d, 64'h8bb21831c60f1002,
                                      64'hb48a92db98d5da62, 64'h43189921b8f8e3e8,
                                      64'h348fa5c9d525e140};
  localparam ascon_state_t VEC_A = {64'h0123456789abcdef, 64'hfedcba9876543210,
                                    64'h0f1e2d3c4b5a6978, 64'h8877665544332211,
                                    64'hdeadbeefcafef00d};
  localparam ascon_state_t VEC_B = {64'h5a5a5a5aa5a5a5a5, 64'h0000000000000001,
                                    64'h8000000000000000, 64'hffffffffffffffff,
                                    64'h13579bdf2468ace0};
  localparam ascon_state_t VEC_C = {64'hc0ffee00badf00d1, 64'h1122334455667788,
                                    64'h99aabbccddeeff00, 64'h0badcafe0badcafe,
                                    64'h7777777722222222};

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_miss;

  ascon_permutation_if bus ();

  ascon_permutation dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic ascon_state_t observed();
    return {bus.S_0_reg, bus.S_1_reg, bus.S_2_reg, bus.S_3_reg, bus.S_4_reg};
  endfunction

  task automatic check_state(input string tag, input ascon_state_t got, input ascon_state_t exp);
    check({tag, "_s0"}, got.x0, exp.x0);
    check({tag, "_s1"}, got.x1, exp.x1);
    check({tag, "_s2"}, got.x2, exp.x2);
    check({tag, "_s3"}, got.x3, exp.x3);
    check({tag, "_s4"}, got.x4, exp.x4);
  endtask

  function automatic logic [63:0] rot(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // Reference permutation using a per-column S-box lookup rather than the bitsliced form.
  function automatic ascon_state_t model_perm(input ascon_state_t s_in, input int nr);
    logic [63:0] x [5];
    logic [63:0] y [5];
    logic [4:0]  v, o;
    x[0] = s_in.x0; x[1] = s_in.x1; x[2] = s_in.x2; x[3] = s_in.x3; x[4] = s_in.x4;
    for (int r = 12 - nr; r < 12; r++) begin
      x[2][7:0] = x[2][7:0] ^ {4'(15 - r), 4'(r)};
      for (int b = 0; b < 64; b++) begin
        v = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
        o = SBOX_TBL[v * 5 +: 5];
        y[0][b] = o[4]; y[1][b] = o[3]; y[2][b] = o[2]; y[3][b] = o[1]; y[4][b] = o[0];
      end
      x[0] = y[0] ^ rot(y[0], 19) ^ rot(y[0], 28);
      x[1] = y[1] ^ rot(y[1], 61) ^ rot(y[1], 39);
      x[2] = y[2] ^ rot(y[2], 1)  ^ rot(y[2], 6);
      x[3] = y[3] ^ rot(y[3], 10) ^ rot(y[3], 17);
      x[4] = y[4] ^ rot(y[4], 7)  ^ rot(y[4], 41);
    end
    return {x[0], x[1], x[2], x[3], x[4]};
  endfunction

  task automatic drive_req(input logic [1:0] sel, input ascon_state_t s, input logic go);
    bus.rounds_sel = sel;
    bus.S_in_0 = s.x0; bus.S_in_1 = s.x1; bus.S_in_2 = s.x2;
    bus.S_in_3 = s.x3; bus.S_in_4 = s.x4;
    bus.start = go;
  endtask

  // Entered at a negedge; returns at the negedge of the DONE cycle (or after a bounded wait).
  task automatic run_op(input string tag, input logic [1:0] sel, input ascon_state_t s_in,
                        input ascon_state_t exp, input int nr, input bit disturb);
    int lat;
    int busy_cnt;
    drive_req(sel, s_in, 1'b1);
    @(negedge clk);
    bus.start = 1'b0;
    lat = -1;
    busy_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      if (c == 0) check({tag, "_done_low"}, 64'(bus.done), 64'd0);
      if (bus.done) begin
        lat = c;
        break;
      end
      if (bus.busy) busy_cnt++;
      if (disturb && c == 2) drive_req(2'b10, VEC_C, 1'b1);
      if (disturb && c == 3) bus.start = 1'b0;
      @(negedge clk);
    end
    check({tag, "_latency"}, 64'(lat), 64'(nr / UNROLL));
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(nr / UNROLL));
    check_state(tag, observed(), exp);
  endtask

  initial begin
    ascon_state_t held;
    int           done_seen, busy_seen;
    n_vec  = 0;
    n_miss = 0;
    rst_n  = 1'b0;
    drive_req(2'b00, '0, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    check_state("reset", observed(), '0);
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_done", 64'(bus.done), 64'd0);

    run_op("kat_p12", 2'b00, KAT_IN, KAT_OUT, 12, 1'b0);
    @(negedge clk);
    check("kat_done_pulse", 64'(bus.done), 64'd0);
    check_state("kat_hold", observed(), KAT_OUT);

    run_op("p8_a", 2'b01, VEC_A, model_perm(VEC_A, 8), 8, 1'b0);
    @(negedge clk);
    run_op("p6_b", 2'b10, VEC_B, model_perm(VEC_B, 6), 6, 1'b0);
    @(negedge clk);

    run_op("p8_disturbed", 2'b01, VEC_B, model_perm(VEC_B, 8), 8, 1'b1);
    @(negedge clk);

    run_op("b2b_first", 2'b10, VEC_C, model_perm(VEC_C, 6), 6, 1'b0);
    run_op("b2b_second", 2'b01, VEC_A, model_perm(VEC_A, 8), 8, 1'b0);
    @(negedge clk);
    check("b2b_done_pulse", 64'(bus.done), 64'd0);

    drive_req(2'b00, KAT_IN, 1'b1);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    check("midrst_busy_before", 64'(bus.busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check_state("midrst", observed(), '0);
    check("midrst_busy", 64'(bus.busy), 64'd0);
    check("midrst_done", 64'(bus.done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op("post_rst_kat", 2'b00, KAT_IN, KAT_OUT, 12, 1'b0);
    @(negedge clk);

    run_op("sel11_kat", 2'b11, KAT_IN, KAT_OUT, 12, 1'b0);
    drive_req(2'b01, VEC_A, 1'b0);
    held = observed();
    done_seen = 0;
    busy_seen = 0;
    repeat (50) begin
      @(negedge clk);
      if (bus.done) done_seen++;
      if (bus.busy) busy_seen++;
      if (observed() !== held) done_seen += 100;
    end
    check("idle_no_activity", 64'(done_seen), 64'd0);
    check("idle_busy", 64'(busy_seen), 64'd0);
    check_state("idle_hold", observed(), KAT_OUT);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
